// File: rtl/map_pkg.sv
// map_pkg: shared FSM encoding, map geometry and sprite field widths for the map port.
package map_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;
  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int SPR_ORIENT_W = 3;
  localparam int SPR_INDEX_W = 5;
  localparam int SPRITE_W = SPR_ORIENT_W + SPR_INDEX_W;
  localparam logic [SPRITE_W-1:0] SPRITE_EMPTY = '0;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin encoder, first request searching upward from last+1.
module rr_picker #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);
  logic [IW-1:0] k;
  always_comb begin
    grant_o = '0;
    k = '0;
    any_o = |req_i;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(last_i) + i) % N);
      if (req_i[k]) grant_o = k;
    end
  end
endmodule

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: round-robin sharing of the single tile-map port among NREQ requesters.
module map_port_arbiter import map_pkg::*; #(
  parameter int NREQ = 4,
  parameter int MAXX = MAP_COLS - 1,
  parameter int MAXY = MAP_ROWS - 1,
  parameter int TIMEOUT = 15
) (
  input  logic                       px_clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_we,
  input  logic [6*NREQ-1:0]          req_x,
  input  logic [6*NREQ-1:0]          req_y,
  input  logic [SPRITE_W*NREQ-1:0]   req_sprite,
  output logic [NREQ-1:0]            ack,
  output logic                       err,
  output logic [SPRITE_W-1:0]        rd_data,
  output logic                       update,
  output logic                       get,
  output logic [5:0]                 posx,
  output logic [5:0]                 posy,
  output logic [SPRITE_W-1:0]        sprite,
  input  logic [SPRITE_W-1:0]        read_sprite,
  input  logic                       ready
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [IW-1:0] last_q, gnt_q, pick;
  logic any, oob, err_q, err_d;
  logic [5:0] x_q, y_q, px, py;
  logic [SPRITE_W-1:0] spr_q, rd_q, ps;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] xs [NREQ];
  logic [5:0] ys [NREQ];
  logic [SPRITE_W-1:0] ss [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign xs[g] = req_x[6*g +: 6];
    assign ys[g] = req_y[6*g +: 6];
    assign ss[g] = req_sprite[SPRITE_W*g +: SPRITE_W];
  end
  rr_picker #(.N(NREQ)) u_pick (.req_i(req), .last_i(last_q), .grant_o(pick), .any_o(any));
  assign px = xs[pick];
  assign py = ys[pick];
  assign ps = ss[pick];
  assign oob = (px > 6'(MAXX)) || (py > 6'(MAXY));
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (any) begin
        state_d = oob ? S_DONE : (req_we[pick] ? S_WR : S_RD);
        err_d = oob;
        cnt_d = '0;
      end
      S_WR: state_d = S_DONE;
      S_RD: begin
        state_d = (ready || cnt_q == CW'(TIMEOUT - 1)) ? S_DONE : S_RD;
        err_d = !ready;
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge px_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      last_q <= IW'(NREQ - 1);
      gnt_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      spr_q <= SPRITE_EMPTY;
      rd_q <= SPRITE_EMPTY;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      if (state_q == S_IDLE && any) begin
        gnt_q <= pick;
        x_q <= px;
        y_q <= py;
        spr_q <= ps;
      end
      if (state_q == S_RD && ready) rd_q <= read_sprite;
      if (state_q == S_DONE) last_q <= gnt_q;
    end
  end
  assign update = state_q == S_WR;
  assign get = state_q == S_RD;
  assign posx = x_q;
  assign posy = y_q;
  assign sprite = spr_q;
  assign rd_data = rd_q;
  assign err = (state_q == S_DONE) && err_q;
  assign ack = (state_q == S_DONE) ? (NREQ'(1) << gnt_q) : '0;
endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: vector table, randomized model checks and hand sequences for the map arbiter.
module tb_map_port_arbiter;
  logic px_clk = 1'b0;
  logic rst;
  logic [3:0] req, req_we, ack;
  logic [23:0] req_x, req_y;
  logic [31:0] req_sprite;
  logic err, update, get, ready;
  logic [7:0] rd_data, sprite, read_sprite;
  logic [5:0] posx, posy;
  int n_tests = 0;
  int n_fail = 0;
  int last_m;
  logic [7:0] rd_m;
  typedef struct {
    int id; bit we; logic [5:0] x; logic [5:0] y; logic [7:0] spr; int rlat; logic [7:0] rdat;
    bit e_err; int e_cyc; int e_upd; int e_get; logic [7:0] e_rd;
  } vec_t;
  vec_t tbl [10];
  map_port_arbiter dut (
    .px_clk(px_clk), .rst(rst), .req(req), .req_we(req_we), .req_x(req_x), .req_y(req_y),
    .req_sprite(req_sprite), .ack(ack), .err(err), .rd_data(rd_data), .update(update),
    .get(get), .posx(posx), .posy(posy), .sprite(sprite), .read_sprite(read_sprite), .ready(ready)
  );
  always #5 px_clk = ~px_clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_outs"}, {ack, err, rd_data, update, get, posx, posy, sprite}, '0);
  endtask
  function automatic vec_t mk(int id, bit we, logic [5:0] x, logic [5:0] y, logic [7:0] spr, int rlat, logic [7:0] rdat);
    vec_t v;
    bit oob = (x > 39) || (y > 29);
    bit hit = !oob && !we && rlat >= 1 && rlat <= 15;
    v = '{id, we, x, y, spr, rlat, rdat, 0, 0, 0, 0, rd_m};
    v.e_err = oob || (!we && !hit);
    v.e_cyc = oob ? 1 : we ? 2 : hit ? rlat + 1 : 16;
    v.e_upd = (!oob && we) ? 1 : 0;
    v.e_get = (oob || we) ? 0 : hit ? rlat : 15;
    v.e_rd = hit ? rdat : rd_m;
    return v;
  endfunction
  task automatic run(input vec_t v);
    int c = 0, upd = 0, gets = 0, both = 0;
    bit done = 0;
    req = '0;
    req[v.id] = 1'b1;
    req_we[v.id] = v.we;
    req_x[6*v.id +: 6] = v.x;
    req_y[6*v.id +: 6] = v.y;
    req_sprite[8*v.id +: 8] = v.spr;
    while (!done && c < 40) begin
      @(posedge px_clk);
      c++;
      @(negedge px_clk);
      if (update && get) both++;
      if (update) begin
        upd++;
        chk("wr_pos", {posx, posy, sprite}, {v.x, v.y, v.spr});
      end
      if (get) begin
        gets++;
        if (gets == 1) chk("rd_pos", {posx, posy}, {v.x, v.y});
        if (gets == v.rlat) begin
          ready = 1'b1;
          read_sprite = v.rdat;
        end
      end
      if (|ack) begin
        done = 1;
        chk("ack_vec", ack, 4'b1 << v.id);
        chk("err", err, v.e_err);
        chk("ack_latency", c, v.e_cyc);
        chk("rd_data", rd_data, v.e_rd);
        ready = 1'b0;
        req = '0;
        last_m = v.id;
        rd_m = v.e_rd;
      end
    end
    if (!done) chk("ack_timeout", 0, 1);
    chk("update_cycles", upd, v.e_upd);
    chk("get_cycles", gets, v.e_get);
    chk("upd_get_overlap", both, 0);
    @(negedge px_clk);
  endtask
  task automatic contend(input logic [3:0] mask, input int nacks);
    int k = 0, cyc = 0, e;
    req = mask;
    req_we = 4'hf;
    for (int i = 0; i < 4; i++) begin
      req_x[6*i +: 6] = 6'(i);
      req_y[6*i +: 6] = 6'(i + 1);
    end
    while (k < nacks && cyc < 300) begin
      @(negedge px_clk);
      cyc++;
      if (|ack) begin
        e = last_m;
        for (int s = 0; s < 4; s++) begin
          e = (e + 1) % 4;
          if (mask[e]) break;
        end
        chk("rr_grant", ack, 4'b1 << e);
        last_m = e;
        k++;
      end
    end
    if (k < nacks) chk("rr_timeout", k, nacks);
    req = '0;
    repeat (3) @(negedge px_clk);
  endtask
  task automatic do_reset();
    @(negedge px_clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(negedge px_clk);
    rst = 1'b1;
    last_m = 3;
    rd_m = 8'h00;
  endtask
  initial begin
    int bad;
    vec_t v;
    rst = 1'b0;
    req = '0; req_we = '0; req_x = '0; req_y = '0; req_sprite = '0;
    ready = 1'b0; read_sprite = '0;
    last_m = 3;
    rd_m = 8'h00;
    tbl[0] = '{0, 1, 6'd6,  6'd6,  8'h22, 0,  8'h00, 0, 2,  1, 0,  8'h00};
    tbl[1] = '{2, 0, 6'd39, 6'd29, 8'h00, 3,  8'h03, 0, 4,  0, 3,  8'h03};
    tbl[2] = '{1, 1, 6'd40, 6'd5,  8'h11, 0,  8'h00, 1, 1,  0, 0,  8'h03};
    tbl[3] = '{3, 1, 6'd3,  6'd30, 8'h12, 0,  8'h00, 1, 1,  0, 0,  8'h03};
    tbl[4] = '{1, 0, 6'd0,  6'd0,  8'h00, 16, 8'hee, 1, 16, 0, 15, 8'h03};
    tbl[5] = '{3, 0, 6'd10, 6'd10, 8'h00, 1,  8'ha5, 0, 2,  0, 1,  8'ha5};
    tbl[6] = '{0, 0, 6'd2,  6'd2,  8'h00, 15, 8'h5a, 0, 16, 0, 15, 8'h5a};
    tbl[7] = '{2, 1, 6'd39, 6'd29, 8'hff, 0,  8'h00, 0, 2,  1, 0,  8'h5a};
    tbl[8] = '{1, 0, 6'd63, 6'd0,  8'h00, 1,  8'h77, 1, 1,  0, 0,  8'h5a};
    tbl[9] = '{0, 1, 6'd0,  6'd0,  8'h00, 0,  8'h00, 0, 2,  1, 0,  8'h5a};
    #2;
    chk_reset_outputs("por");
    @(negedge px_clk);
    rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge px_clk);
      if (update || get || |ack) bad++;
    end
    chk("idle_quiet", bad, 0);
    for (int i = 0; i < 10; i++) run(tbl[i]);
    rd_m = tbl[9].e_rd;
    for (int i = 0; i < 40; i++) begin
      v = mk($urandom_range(0, 3), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 45)),
             6'($urandom_range(0, 35)), 8'($urandom), $urandom_range(0, 17), 8'($urandom));
      run(v);
    end
    do_reset();
    contend(4'b1111, 5);
    for (int i = 0; i < 4; i++) contend(4'($urandom_range(1, 15)), 6);
    do_reset();
    req = 4'b0010; req_we = 4'b0000;
    req_x[6 +: 6] = 6'd5; req_y[6 +: 6] = 6'd5;
    @(posedge px_clk);
    @(negedge px_clk);
    chk("mid_rd_get", get, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_get_drop", {get, update, ack}, '0);
    chk_reset_outputs("mid_rd_reset");
    @(negedge px_clk);
    req = '0;
    rst = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge px_clk);
      if (|ack || get) bad++;
    end
    chk("no_ack_after_reset", bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
